// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending machine core and its neighbours.
// No logic; imported by vend_controller and coin_value_decode.
package vend_pkg;

  typedef enum logic [1:0] {
    NICKEL  = 2'b00,
    DIME    = 2'b01,
    QUARTER = 2'b10,
    SLUG    = 2'b11
  } coin_t;

  localparam int NICKEL_VAL  = 5;
  localparam int DIME_VAL    = 10;
  localparam int QUARTER_VAL = 25;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_t;

endpackage

// File: rtl/vend_coin_value_decode.sv
// Combinational coin -> cents decode; slugs report valid_o = 0 and value 0.
// Zero latency, no flow control.
module coin_value_decode
  import vend_pkg::*;
(
  input  coin_t       coin_i,
  output logic [4:0]  value_o,
  output logic        valid_o
);

  always_comb begin
    value_o = '0;
    valid_o = 1'b1;
    case (coin_i)
      NICKEL:  value_o = 5'(NICKEL_VAL);
      DIME:    value_o = 5'(DIME_VAL);
      QUARTER: value_o = 5'(QUARTER_VAL);
      SLUG:    valid_o = 1'b0;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vend_controller.sv
// Vending FSM: credit accumulation, one-cycle vend, greedy serial change output.
// All outputs registered (one cycle after the sampling edge); coins are rejected while busy.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE      = 65,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                select,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                busy
);

  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] Q_C     = CREDIT_W'(QUARTER_VAL);
  localparam logic [CREDIT_W-1:0] D_C     = CREDIT_W'(DIME_VAL);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic                reject_q, reject_d;
  logic                chg_vld_q, chg_vld_d;
  coin_t               chg_coin_q, chg_coin_d;

  logic [4:0]          coin_val;
  logic                coin_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  coin_t               pick_coin;
  logic [4:0]          pick_val;
  logic [CREDIT_W-1:0] pick_rem;

  coin_value_decode u_coin_dec (
    .coin_i  (coin_t'(coin_type)),
    .value_o (coin_val),
    .valid_o (coin_ok)
  );

  // One extra bit on the sum so an overflowing add cannot wrap under MAX_CREDIT.
  assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
  assign coin_fits = coin_ok && (coin_sum <= MAX_X);

  always_comb begin
    pick_coin = NICKEL;
    pick_val  = 5'(NICKEL_VAL);
    if (credit_q >= Q_C) begin
      pick_coin = QUARTER;
      pick_val  = 5'(QUARTER_VAL);
    end else if (credit_q >= D_C) begin
      pick_coin = DIME;
      pick_val  = 5'(DIME_VAL);
    end
  end

  assign pick_rem = credit_q - CREDIT_W'(pick_val);

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    reject_d   = 1'b0;
    chg_vld_d  = 1'b0;
    chg_coin_d = NICKEL;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (cancel && state_q == COLLECT) begin
          state_d    = CHANGE;
          credit_d   = pick_rem;
          chg_vld_d  = 1'b1;
          chg_coin_d = pick_coin;
          reject_d   = coin_valid;
        end else if (select && ({1'b0, credit_q} >= PRICE_X)) begin
          state_d    = VEND;
          credit_d   = credit_q - PRICE_X[CREDIT_W-1:0];
          dispense_d = 1'b1;
          reject_d   = coin_valid;
        end else if (coin_valid) begin
          if (coin_fits) begin
            state_d  = COLLECT;
            credit_d = coin_sum[CREDIT_W-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      // CHANGE is held for the cycle showing the last coin so busy covers it.
      VEND, CHANGE: begin
        reject_d = coin_valid;
        if (credit_q != '0) begin
          state_d    = CHANGE;
          credit_d   = pick_rem;
          chg_vld_d  = 1'b1;
          chg_coin_d = pick_coin;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
      chg_vld_q  <= 1'b0;
      chg_coin_q <= NICKEL;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      reject_q   <= reject_d;
      chg_vld_q  <= chg_vld_d;
      chg_coin_q <= chg_coin_d;
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign coin_reject  = reject_q;
  assign change_valid = chg_vld_q;
  assign change_coin  = chg_coin_q;
  assign busy         = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: cents-level model with a change queue,
// compared every cycle, plus hand-computed literal expectations.
module tb_vend_controller;

  localparam int PRICE = 65;
  localparam int CW    = 8;
  localparam int MAXC  = 250;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin_type = 2'b00;
  logic          select = 1'b0;
  logic          cancel = 1'b0;
  logic [CW-1:0] credit;
  logic          dispense, coin_reject, change_valid, busy;
  logic [1:0]    change_coin;

  vend_controller #(.PRICE(PRICE), .CREDIT_W(CW), .MAX_CREDIT(MAXC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .select       (select),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .coin_reject  (coin_reject),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_credit = 0;
  bit m_disp = 0, m_rej = 0, m_cv = 0;
  int m_cc = 0;
  int chg_q[$];

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cents(input logic [1:0] ct);
    case (ct)
      2'b00:   return 5;
      2'b01:   return 10;
      2'b10:   return 25;
      default: return -1;
    endcase
  endfunction

  task automatic make_change(input int amount);
    int c;
    c = amount;
    chg_q.delete();
    while (c > 0) begin
      if (c >= 25) begin chg_q.push_back(25); c -= 25; end
      else if (c >= 10) begin chg_q.push_back(10); c -= 10; end
      else begin chg_q.push_back(5); c -= 5; end
    end
  endtask

  task automatic pop_change();
    int v;
    if (chg_q.size() > 0) begin
      v = chg_q.pop_front();
      m_credit -= v;
      m_cv = 1'b1;
      m_cc = (v == 25) ? 2 : (v == 10) ? 1 : 0;
    end
  endtask

  // Expected outputs for the cycle after this edge, from the inputs sampled at it.
  task automatic model_step();
    bit was_busy;
    int v;
    was_busy = m_disp || m_cv;
    m_disp = 1'b0; m_rej = 1'b0; m_cv = 1'b0; m_cc = 0;
    if (!rst_n) begin
      m_credit = 0;
      chg_q.delete();
    end else if (was_busy) begin
      m_rej = coin_valid;
      pop_change();
    end else if (cancel && m_credit > 0) begin
      m_rej = coin_valid;
      make_change(m_credit);
      pop_change();
    end else if (select && m_credit >= PRICE) begin
      m_rej = coin_valid;
      m_credit -= PRICE;
      m_disp = 1'b1;
      make_change(m_credit);
    end else if (coin_valid) begin
      v = cents(coin_type);
      if (v < 0 || m_credit + v > MAXC) m_rej = 1'b1;
      else m_credit += v;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("credit", int'(credit), m_credit);
      cmp("dispense", int'(dispense), int'(m_disp));
      cmp("coin_reject", int'(coin_reject), int'(m_rej));
      cmp("change_valid", int'(change_valid), int'(m_cv));
      cmp("change_coin", int'(change_coin), m_cc);
      cmp("busy", int'(busy), int'(m_disp || m_cv));
    end
  end

  task automatic step(input bit cv, input logic [1:0] ct, input bit sel, input bit can, input bit rst);
    coin_valid = cv; coin_type = ct; select = sel; cancel = can; rst_n = rst;
    @(posedge clk);
    model_step();
    @(negedge clk);
    coin_valid = 1'b0; select = 1'b0; cancel = 1'b0;
  endtask

  task automatic coin(input logic [1:0] ct); step(1, ct, 0, 0, 1); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 1); endtask

  initial begin
    step(0, 2'b00, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 2'b00, 0, 0, 0);
    cmp("rst_credit", int'(credit), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_change_valid", int'(change_valid), 0);
    idle(1);

    // Exact price
    coin(2'b10); cmp("exact_c25", int'(credit), 25);
    coin(2'b10); cmp("exact_c50", int'(credit), 50);
    coin(2'b01); cmp("exact_c60", int'(credit), 60);
    coin(2'b00); cmp("exact_c65", int'(credit), 65);
    step(0, 2'b00, 1, 0, 1);
    cmp("exact_dispense", int'(dispense), 1);
    cmp("exact_credit0", int'(credit), 0);
    idle(1);
    cmp("exact_nochange", int'(change_valid), 0);
    cmp("exact_idle_busy", int'(busy), 0);

    // Overpay: 100 -> dispense, quarter, dime
    repeat (4) coin(2'b10);
    step(0, 2'b00, 1, 0, 1);
    cmp("over_credit35", int'(credit), 35);
    idle(1);
    cmp("over_chg1", int'(change_coin), 2);
    cmp("over_credit10", int'(credit), 10);
    idle(1);
    cmp("over_chg2", int'(change_coin), 1);
    cmp("over_busy_last", int'(busy), 1);
    idle(1);
    cmp("over_busy_drop", int'(busy), 0);

    // Underpay and slug
    coin(2'b01);
    step(0, 2'b00, 1, 0, 1);
    cmp("under_nodisp", int'(dispense), 0);
    cmp("under_credit10", int'(credit), 10);
    coin(2'b11);
    cmp("slug_reject", int'(coin_reject), 1);
    cmp("slug_credit10", int'(credit), 10);
    step(0, 2'b00, 0, 1, 1);
    idle(2);

    // Cancel in IDLE with a coin: cancel ignored, coin accepted
    step(1, 2'b00, 0, 1, 1);
    cmp("idle_cancel_credit", int'(credit), 5);
    cmp("idle_cancel_busy", int'(busy), 0);
    step(0, 2'b00, 0, 1, 1);
    idle(2);

    // Cancel 40 -> quarter, dime, nickel
    coin(2'b01); coin(2'b00); coin(2'b10);
    step(0, 2'b00, 0, 1, 1);
    cmp("cancel_chg1", int'(change_coin), 2);
    cmp("cancel_credit15", int'(credit), 15);
    idle(1);
    cmp("cancel_chg2", int'(change_coin), 1);
    idle(1);
    cmp("cancel_chg3", int'(change_coin), 0);
    cmp("cancel_nodisp", int'(dispense), 0);
    idle(2);

    // Select with a simultaneous quarter at credit 70
    coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b01);
    step(1, 2'b10, 1, 0, 1);
    cmp("simul_disp", int'(dispense), 1);
    cmp("simul_reject", int'(coin_reject), 1);
    cmp("simul_credit5", int'(credit), 5);
    idle(3);

    // Overflow boundary
    repeat (9) coin(2'b10);
    coin(2'b01); coin(2'b00);
    cmp("ovf_credit240", int'(credit), 240);
    coin(2'b10);
    cmp("ovf_reject", int'(coin_reject), 1);
    cmp("ovf_credit_kept", int'(credit), 240);
    coin(2'b01);
    cmp("ovf_credit250", int'(credit), 250);
    coin(2'b00);
    cmp("ovf_reject_max", int'(coin_reject), 1);
    step(0, 2'b00, 0, 1, 1);
    idle(1);
    coin(2'b00);
    cmp("change_coin_reject", int'(coin_reject), 1);
    idle(10);

    // Reset during the second change cycle
    repeat (4) coin(2'b10);
    coin(2'b01);
    step(0, 2'b00, 0, 1, 1);
    idle(1);
    cmp("rstmid_credit60", int'(credit), 60);
    step(0, 2'b00, 0, 0, 0);
    cmp("rstmid_credit", int'(credit), 0);
    cmp("rstmid_cv", int'(change_valid), 0);
    cmp("rstmid_busy", int'(busy), 0);
    idle(2);
    coin(2'b01);
    cmp("rstmid_resume", int'(credit), 10);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequential core of the digital vending machine. Accepts coin pulses, accumulates credit, and dispenses one item when a selection is made with sufficient credit. Returns change as a serial stream of coins. It sits downstream of the combinational input-decode exercises (coin/select conditioning) and upstream of the display and actuator logic.

## Interface
Parameters:
- PRICE, 65: item price in cents; must be a multiple of 5.
- CREDIT_W, 8: width of the credit register.
- MAX_CREDIT, 250: highest credit accepted, in cents; multiple of 5.

Ports:
- clk  in  1  system clock; one clock; everything is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- coin_valid  in  1  one-cycle strobe: a coin is presented.
- coin_type  in  2  00 = nickel (5), 01 = dime (10), 10 = quarter (25), 11 = slug (invalid).
- select  in  1  one-cycle vend request.
- cancel  in  1  one-cycle refund request.
- credit  out  CREDIT_W  current credit in cents.
- dispense  out  1  one-cycle pulse that releases the item.
- coin_reject  out  1  one-cycle pulse: the presented coin was returned.
- change_valid  out  1  a change coin is being ejected this cycle.
- change_coin  out  2  coin ejected; same encoding as coin_type; 00 when change_valid = 0.
- busy  out  1  high in VEND and CHANGE.

## Operation
States: IDLE, COLLECT, VEND, CHANGE.
- IDLE: credit = 0. A valid coin moves to COLLECT.
- COLLECT (and IDLE), per-cycle priority is cancel > select > coin:
  - cancel: go to CHANGE with the full credit; no dispense. A cancel in IDLE is ignored.
  - select with credit ≥ PRICE: go to VEND.
  - select with credit < PRICE: ignored; a coin in the same cycle is still processed.
  - A coin presented in the same cycle as an accepted cancel or select is rejected.
  - Coin acceptance: credit_next = credit + value. Slug, or credit + value > MAX_CREDIT, gives coin_reject and leaves credit unchanged.
- VEND: one cycle. dispense = 1 and credit -= PRICE. Next state is CHANGE if remaining credit > 0, else IDLE.
- CHANGE: each cycle, eject the largest coin ≤ remaining credit (quarter > dime > nickel) and subtract it. Move to IDLE in the same cycle the remainder reaches 0.
- In VEND and CHANGE, select and cancel are ignored and every coin_valid is rejected.
- Arithmetic: the sum uses CREDIT_W+1 bits to detect overflow. Credit is always a multiple of 5, so change always completes exactly.

## Timing
- All outputs are registered and reflect the state after the edge on which inputs were sampled.
- Coin accepted at edge n: credit updates after edge n. A rejected coin gives coin_reject high for the cycle after edge n.
- Select accepted at edge n: dispense is high in cycle n+1. The first change coin appears in cycle n+2.
- Change: one coin per cycle, no gaps. The credit shown during a change cycle is the remainder after that coin.
- busy is high from the cycle dispense asserts (or the first change cycle after cancel) through the last change cycle. It drops the cycle state returns to IDLE.
- Reset: at any edge with rst_n = 0, state = IDLE, credit = 0, and all pulses and change_coin = 0. Remaining change or credit is discarded, including reset mid-CHANGE.

## Structure
- Package vend_pkg holds:
  - coin_t enum (NICKEL, DIME, QUARTER, SLUG);
  - constants NICKEL_VAL = 5, DIME_VAL = 10, QUARTER_VAL = 25;
  - state_t enum (IDLE, COLLECT, VEND, CHANGE).
- Sub-module coin_value_decode (combinational): coin_t → cents value plus a valid flag. It is shared with the display block.
- Everything else (FSM, credit register, change selector) lives in vend_controller.

## Test plan
- Exact price: quarter, quarter, dime, nickel, then select → credit goes 25/50/60/65; dispense one cycle later; credit 0, no change, back to IDLE.
- Overpay: four quarters (credit 100), then select → dispense, then change quarter then dime on consecutive cycles; credit shows 35/10/0; busy drops the next cycle.
- Underpay and slug: dime, then select → no dispense, credit stays 10. coin_type = 11 → coin_reject pulse, credit stays 10.
- Cancel: dime + nickel + quarter (40), then cancel → change quarter, dime, nickel; no dispense.
- Simultaneous events and overflow:
  - Credit 70, select together with a quarter → dispense and quarter rejected.
  - Credit 240, quarter → rejected, credit stays 240.
  - Coin during CHANGE → rejected.
- Reset mid-operation: rst_n low during the second change cycle → next cycle credit = 0, change_valid = 0, busy = 0, state IDLE.
